tt_um_hoene_led_frame_capture: RTL and testbench

Smart-LED frame capture stage, directly downstream of `tt_um_hoene_protocol_insync`. Consumes the synchronised bit stream (`out_data`/`out_clk`/`insync`) and keeps the first 24 bits of each frame as this LED's GRB colour. It forwards every following bit unchanged to the next LED in the chain. On frame end (insync falling) it latches the captured colour to the PWM-facing outputs.

---
 rtl/tt_um_hoene_pkg.sv | 25 ++
 rtl/tt_um_hoene_led_frame_capture_if.sv | 10 +
 rtl/tt_um_hoene_edge_detect.sv | 21 ++
 rtl/tt_um_hoene_led_frame_capture.sv | 113 +++++++++++
 tb/tb_tt_um_hoene_led_frame_capture.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/tt_um_hoene_pkg.sv
// Shared definitions for the hoene smart-LED pipeline stages.
// Holds the frame geometry, FSM encoding and channel slice helpers.
package tt_um_hoene_pkg;

  localparam int unsigned CH_BITS_DEFAULT  = 8;
  localparam int unsigned CHANNELS_DEFAULT = 3;
  localparam int unsigned LED_BITS         = CH_BITS_DEFAULT * CHANNELS_DEFAULT;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAPTURE = 2'd1,
    ST_FORWARD = 2'd2
  } state_t;

  // Channel index counted from the LSB end of the shift register (G arrives first).
  localparam int unsigned CH_IDX_G = 2;
  localparam int unsigned CH_IDX_R = 1;
  localparam int unsigned CH_IDX_B = 0;

  // With the default 8-bit channels this yields G=16, R=8, B=0.
  function automatic int unsigned ch_lsb(input int unsigned ch_idx, input int unsigned ch_bits);
    return ch_idx * ch_bits;
  endfunction

endpackage

// File: rtl/tt_um_hoene_led_frame_capture_if.sv
// Synchronised smart-LED bit stream: frame-valid level, bit value and bit strobe.
// The master drives a stream into a stage, the slave consumes it.
interface tt_um_hoene_led_frame_capture_if;
  logic insync;
  logic data;
  logic strobe;

  modport master (output insync, output data, output strobe);
  modport slave  (input  insync, input  data, input  strobe);
endinterface

// File: rtl/tt_um_hoene_edge_detect.sv
// Registers a level and reports its rising and falling edges as same-cycle pulses.
module tt_um_hoene_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic sig,
  output logic rise,
  output logic fall
);

  logic sig_q;

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) sig_q <= 1'b0;
    else     sig_q <= sig;
  end

  assign rise = sig & ~sig_q;
  assign fall = ~sig & sig_q;

endmodule

// File: rtl/tt_um_hoene_led_frame_capture.sv
// Keeps the first LED_BITS bits of each frame as this LED's GRB colour and forwards
// the rest to the next LED; the colour is latched on frame end.
module tt_um_hoene_led_frame_capture
  import tt_um_hoene_pkg::*;
#(
  parameter int unsigned CH_BITS  = CH_BITS_DEFAULT,
  parameter int unsigned CHANNELS = CHANNELS_DEFAULT
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_insync,
  input  logic               in_data,
  input  logic               in_clk,
  output logic [CH_BITS-1:0] out_green,
  output logic [CH_BITS-1:0] out_red,
  output logic [CH_BITS-1:0] out_blue,
  output logic               out_fwd_data,
  output logic               out_fwd_clk,
  output logic               out_frame_done,
  output logic               out_short
);

  localparam int unsigned LB    = CH_BITS * CHANNELS;
  localparam int unsigned CNT_W = $clog2(LB + 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(LB);
  localparam int unsigned G_LSB = ch_lsb(CH_IDX_G, CH_BITS);
  localparam int unsigned R_LSB = ch_lsb(CH_IDX_R, CH_BITS);
  localparam int unsigned B_LSB = ch_lsb(CH_IDX_B, CH_BITS);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [LB-1:0]    shreg;
  logic             clk_rise, clk_fall_unused;
  logic             sync_rise_unused, sync_fall;
  logic             bit_event;

  tt_um_hoene_edge_detect u_clk_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (in_clk),
    .rise (clk_rise),
    .fall (clk_fall_unused)
  );

  tt_um_hoene_edge_detect u_sync_edge (
    .clk  (clk),
    .rst  (rst),
    .sig  (in_insync),
    .rise (sync_rise_unused),
    .fall (sync_fall)
  );

  // A strobe edge that coincides with insync falling is dropped here.
  assign bit_event = clk_rise & in_insync;

  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      shreg          <= '0;
      out_green      <= '0;
      out_red        <= '0;
      out_blue       <= '0;
      out_fwd_data   <= 1'b0;
      out_fwd_clk    <= 1'b0;
      out_frame_done <= 1'b0;
      out_short      <= 1'b0;
    end else begin
      out_fwd_clk    <= 1'b0;
      out_frame_done <= 1'b0;
      out_short      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (in_insync) begin
            state <= ST_CAPTURE;
            if (bit_event) begin
              shreg <= {shreg[LB-2:0], in_data};
              cnt   <= CNT_W'(1);
            end else begin
              cnt   <= '0;
            end
          end
        end
        ST_CAPTURE, ST_FORWARD: begin
          if (sync_fall) begin
            if (cnt == CNT_FULL) begin
              out_green      <= shreg[G_LSB +: CH_BITS];
              out_red        <= shreg[R_LSB +: CH_BITS];
              out_blue       <= shreg[B_LSB +: CH_BITS];
              out_frame_done <= 1'b1;
            end else begin
              out_short      <= 1'b1;
            end
            state <= ST_IDLE;
            cnt   <= '0;
          end else if (bit_event) begin
            if (state == ST_CAPTURE) begin
              shreg <= {shreg[LB-2:0], in_data};
              cnt   <= cnt + 1'b1;
              // Leaving CAPTURE on the last colour bit is what saturates cnt.
              if (cnt == CNT_FULL - 1'b1) state <= ST_FORWARD;
            end else begin
              out_fwd_data <= in_data;
              out_fwd_clk  <= 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tt_um_hoene_led_frame_capture.sv
// Randomised frame stimulus checked every cycle against a queue-based frame model,
// plus literal checks for the documented scenarios.
module tb_tt_um_hoene_led_frame_capture;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] out_green, out_red, out_blue;
  logic       out_fwd_data, out_fwd_clk, out_frame_done, out_short;

  tt_um_hoene_led_frame_capture_if up ();

  tt_um_hoene_led_frame_capture dut (
    .clk            (clk),
    .rst            (rst),
    .in_insync      (up.insync),
    .in_data        (up.data),
    .in_clk         (up.strobe),
    .out_green      (out_green),
    .out_red        (out_red),
    .out_blue       (out_blue),
    .out_fwd_data   (out_fwd_data),
    .out_fwd_clk    (out_fwd_clk),
    .out_frame_done (out_frame_done),
    .out_short      (out_short)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level model: a frame is the list of bits accepted while insync is high.
  bit        m_prev_clk, m_prev_sync, m_in_frame;
  bit        m_bits[$];
  logic [7:0] e_g, e_r, e_b;
  logic       e_fd, e_fc, e_done, e_short;

  always @(posedge clk) begin
    e_fc    = 1'b0;
    e_done  = 1'b0;
    e_short = 1'b0;
    if (rst) begin
      m_prev_clk = 1'b0; m_prev_sync = 1'b0; m_in_frame = 1'b0;
      m_bits.delete();
      e_g = '0; e_r = '0; e_b = '0; e_fd = 1'b0;
    end else begin
      if (!up.insync && m_prev_sync && m_in_frame) begin
        if (m_bits.size() >= 24) begin
          logic [23:0] v;
          v = '0;
          for (int i = 0; i < 24; i++) v = {v[22:0], m_bits[i]};
          e_g = v[23:16]; e_r = v[15:8]; e_b = v[7:0];
          e_done = 1'b1;
        end else begin
          e_short = 1'b1;
        end
        m_bits.delete();
        m_in_frame = 1'b0;
      end else if (up.insync) begin
        m_in_frame = 1'b1;
        if (up.strobe && !m_prev_clk) begin
          if (m_bits.size() >= 24) begin
            e_fd = up.data;
            e_fc = 1'b1;
          end
          m_bits.push_back(up.data);
        end
      end
      m_prev_clk  = up.strobe;
      m_prev_sync = up.insync;
    end
  end

  bit checking = 1'b0;
  int fwd_cnt = 0, done_cnt = 0, short_cnt = 0;
  bit fwd_q[$];

  always @(negedge clk) begin
    if (checking) begin
      check("cycle", {out_green, out_red, out_blue, out_fwd_data, out_fwd_clk, out_frame_done, out_short},
                     {e_g, e_r, e_b, e_fd, e_fc, e_done, e_short});
      if (out_fwd_clk === 1'b1) begin
        fwd_cnt++;
        fwd_q.push_back(out_fwd_data);
      end
      if (out_frame_done === 1'b1) done_cnt++;
      if (out_short === 1'b1) short_cnt++;
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic bit_out(input bit b, input int gap);
    up.data   = b;
    up.strobe = 1'b1;
    step(1);
    up.strobe = 1'b0;
    up.data   = 1'($urandom);
    step(gap);
  endtask

  task automatic frame(input logic [63:0] v, input int n, input bit rise_with_first);
    up.insync = 1'b1;
    if (!rise_with_first || n == 0) step($urandom_range(1, 3));
    for (int i = n - 1; i >= 0; i--) bit_out(v[i], $urandom_range(1, 2));
    up.insync = 1'b0;
    step($urandom_range(2, 4));
  endtask

  initial begin
    int d0, s0, f0;
    logic [7:0] fb;
    logic [63:0] rv;
    rst = 1'b1; up.insync = 1'b0; up.data = 1'b0; up.strobe = 1'b0;
    step(1);
    checking = 1'b1;
    check("reset_outputs", {out_green, out_red, out_blue, out_fwd_data, out_fwd_clk, out_frame_done, out_short}, '0);
    step(2);
    rst = 1'b0;
    step(2);

    // Full 24-bit frame.
    d0 = done_cnt; f0 = fwd_cnt;
    frame(64'h123456, 24, 1'b0);
    check("t1_green", out_green, 8'h12);
    check("t1_red",   out_red,   8'h34);
    check("t1_blue",  out_blue,  8'h56);
    check("t1_done_pulses", done_cnt - d0, 1);
    check("t1_fwd_pulses",  fwd_cnt - f0, 0);

    // Short frame keeps the previous colour.
    d0 = done_cnt; s0 = short_cnt;
    frame(64'h2B5, 10, 1'b0);
    check("t3_short_pulses", short_cnt - s0, 1);
    check("t3_done_pulses",  done_cnt - d0, 0);
    check("t3_colour", {out_green, out_red, out_blue}, 24'h123456);

    // 32-bit frame, insync rising together with bit 0.
    f0 = fwd_cnt; fwd_q.delete();
    frame({32'h0, 24'hFFFFFF, 8'hA5}, 32, 1'b1);
    check("t2_fwd_pulses", fwd_cnt - f0, 8);
    fb = '0;
    foreach (fwd_q[i]) fb = {fb[6:0], fwd_q[i]};
    check("t2_fwd_bits", fb, 8'hA5);
    check("t2_colour", {out_green, out_red, out_blue}, 24'hFFFFFF);

    // Reset mid-frame discards the partial frame silently.
    s0 = short_cnt;
    up.insync = 1'b1;
    step(1);
    for (int i = 0; i < 12; i++) bit_out(1'b1, 1);
    rst = 1'b1; up.insync = 1'b0;
    step(1);
    check("t4_reset_outputs", {out_green, out_red, out_blue, out_fwd_data, out_fwd_clk, out_frame_done, out_short}, '0);
    step(2);
    rst = 1'b0;
    step(2);
    check("t4_no_short", short_cnt - s0, 0);
    frame(64'h00FF00, 24, 1'b0);
    check("t4_colour", {out_green, out_red, out_blue}, 24'h00FF00);

    // Strobes while insync is low are ignored.
    for (int i = 0; i < 3; i++) bit_out(1'b1, 1);
    frame(64'hABCDEF, 24, 1'b0);
    check("t5_colour", {out_green, out_red, out_blue}, 24'hABCDEF);

    // 23 bits plus a strobe on the insync-falling cycle is still short.
    s0 = short_cnt; d0 = done_cnt;
    up.insync = 1'b1;
    step(1);
    for (int i = 0; i < 23; i++) bit_out(1'($urandom), 1);
    up.insync = 1'b0; up.strobe = 1'b1; up.data = 1'b1;
    step(1);
    up.strobe = 1'b0;
    step(3);
    check("t6_short_pulses", short_cnt - s0, 1);
    check("t6_done_pulses",  done_cnt - d0, 0);
    check("t6_colour", {out_green, out_red, out_blue}, 24'hABCDEF);

    // Random frames, stray strobes and occasional mid-frame resets.
    for (int k = 0; k < 40; k++) begin
      rv = {$urandom, $urandom};
      if ($urandom_range(0, 3) == 0) bit_out(1'($urandom), $urandom_range(1, 2));
      if ($urandom_range(0, 7) == 0) begin
        up.insync = 1'b1;
        for (int i = 0; i < int'($urandom_range(0, 30)); i++) bit_out(rv[i], 1);
        rst = 1'b1; up.insync = 1'b0;
        step($urandom_range(1, 2));
        rst = 1'b0;
        step(1);
      end else begin
        frame(rv, $urandom_range(0, 40), 1'($urandom));
      end
    end
    step(3);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
